// File: rtl/prog_loader.sv
// UART boot loader: parses A5 | LEN_H | LEN_L | {DATA_H, DATA_L} x N [| CSUM] into instruction-memory writes.
// Optional checksum byte compiled in with macro PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned addr_width = 12,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [addr_width-1:0] w_addr,
    output logic [15:0]           din,
    output logic                  w_en,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  START_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_H,
        LEN_L,
        DATA_H,
        DATA_L,
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t                r_state;
    logic [7:0]            r_len_h;
    logic [7:0]            r_data_h;
    logic [addr_width-1:0] r_len;
    logic [addr_width-1:0] r_idx;
    logic [TW-1:0]         r_timer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]            r_sum;
`endif

    logic                  w_active;
    logic                  w_tmo;
    logic                  w_last;
    logic [addr_width-1:0] w_len_new;

    assign w_active  = (r_state != IDLE) && (r_state != DONE);
    assign w_tmo     = w_active && (r_timer == TW'(TIMEOUT - 1));
    // N==0 wraps to all-ones here, giving the full 2^addr_width words.
    assign w_last    = (r_idx == (r_len - addr_width'(1)));
    assign w_len_new = addr_width'({r_len_h, rx_data});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_len_h  <= '0;
            r_data_h <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_timer  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum    <= '0;
`endif
            w_addr   <= '0;
            din      <= '0;
            w_en     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            w_en <= 1'b0;
            // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
            if (w_tmo) begin
                r_state  <= DONE;
                err      <= 1'b1;
                done     <= 1'b0;
                cpu_hold <= 1'b0;
            end else begin
                if (w_active) begin
                    r_timer <= rx_valid ? '0 : r_timer + TW'(1);
                end
                if (rx_valid) begin
                    case (r_state)
                        IDLE, DONE: begin
                            if (rx_data == START_BYTE) begin
                                r_state  <= LEN_H;
                                cpu_hold <= 1'b1;
                                done     <= 1'b0;
                                err      <= 1'b0;
                                r_idx    <= '0;
                                w_addr   <= '0;
                                r_timer  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                                r_sum    <= '0;
`endif
                            end
                        end
                        LEN_H: begin
                            r_len_h <= rx_data;
                            r_state <= LEN_L;
                        end
                        LEN_L: begin
                            r_len   <= w_len_new;
                            r_state <= DATA_H;
                        end
                        DATA_H: begin
                            r_data_h <= rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_sum    <= r_sum + rx_data;
`endif
                            r_state  <= DATA_L;
                        end
                        DATA_L: begin
                            w_en   <= 1'b1;
                            din    <= {r_data_h, rx_data};
                            w_addr <= r_idx;
                            r_idx  <= r_idx + addr_width'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_sum  <= r_sum + rx_data;
`endif
                            if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                                r_state  <= CSUM;
`else
                                r_state  <= DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
`endif
                            end else begin
                                r_state <= DATA_H;
                            end
                        end
`ifdef PROG_LOADER_CHECKSUM_EN
                        CSUM: begin
                            r_state  <= DONE;
                            cpu_hold <= 1'b0;
                            if (rx_data == r_sum) begin
                                done <= 1'b1;
                            end else begin
                                err  <= 1'b1;
                            end
                        end
`endif
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (addr_width=4, TIMEOUT=16); checksum steps follow PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

    localparam int unsigned AW  = 4;
    localparam int unsigned TMO = 16;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] w_addr;
    logic [15:0]   din;
    logic          w_en;
    logic          cpu_hold;
    logic          done;
    logic          err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int wr_base = 0;

    prog_loader #(.addr_width(AW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .w_addr   (w_addr),
        .din      (din),
        .w_en     (w_en),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_en === 1'b1) wr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_done, input logic exp_err);
        check({tag, "_hold"}, 32'(cpu_hold), 32'(1'b0));
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"},  32'(err),  32'(exp_err));
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] sum;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_wen",   32'(w_en),   32'(0));
        check("rst_waddr", 32'(w_addr), 32'(0));
        check("rst_din",   32'(din),    32'(0));
        check_idle_outputs("rst", 1'b0, 1'b0);
        rst = 1'b1;

        // Non-start bytes in IDLE are ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check_idle_outputs("idle_junk", 1'b0, 1'b0);
        check("idle_junk_wr", 32'(wr_cnt), 32'(0));

        // Two-word frame
        send_byte(8'hA5);
        check("f1_hold", 32'(cpu_hold), 32'(1));
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        check("f1_no_early_wen", 32'(w_en), 32'(0));
        send_byte(8'h34);
        check("f1_w0_wen",  32'(w_en),   32'(1));
        check("f1_w0_din",  32'(din),    32'h1234);
        check("f1_w0_addr", 32'(w_addr), 32'(0));
        @(negedge clk); #1;
        check("f1_w0_pulse", 32'(w_en), 32'(0));
        check("f1_w0_hold_din", 32'(din), 32'h1234);
        send_byte(8'hAB);
        send_byte(8'hCD);
        check("f1_w1_wen",  32'(w_en),   32'(1));
        check("f1_w1_din",  32'(din),    32'hABCD);
        check("f1_w1_addr", 32'(w_addr), 32'(1));
`ifdef PROG_LOADER_CHECKSUM_EN
        check("f1_csum_pending", 32'(done), 32'(0));
        send_byte(8'hBE);
`endif
        check_idle_outputs("f1_end", 1'b1, 1'b0);
        @(negedge clk); #1;
        check("f1_wr_cnt", 32'(wr_cnt), 32'(2));
        check("f1_din_stable", 32'(din), 32'hABCD);
        send_byte(8'h12);
        check_idle_outputs("done_ignore", 1'b1, 1'b0);

        // 0xA5 inside a frame is data
        send_byte(8'hA5);
        check("f2_done_clr", 32'(done), 32'(0));
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hA5);
        send_byte(8'h5A);
        check("f2_din",  32'(din),    32'hA55A);
        check("f2_addr", 32'(w_addr), 32'(0));
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'hFF);
`endif
        check_idle_outputs("f2_end", 1'b1, 1'b0);

        // One-word frame, good then bad checksum
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        check("f3_din", 32'(din), 32'h0102);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h03);
        check_idle_outputs("f3_good", 1'b1, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h04);
        check_idle_outputs("f3_bad", 1'b0, 1'b1);
`else
        check_idle_outputs("f3_good", 1'b1, 1'b0);
`endif

        // Mid-frame silence; a byte landing on the timeout edge is dropped
        wr_base = wr_cnt;
        send_byte(8'hA5);
        check("tmo_err_clr", 32'(err), 32'(0));
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet", 32'(err), 32'(0));
        check("tmo_hold_yet", 32'(cpu_hold), 32'(1));
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check_idle_outputs("tmo", 1'b0, 1'b1);
        @(negedge clk); #1;
        check("tmo_no_write", 32'(wr_cnt), 32'(wr_base));

        // Reset while waiting for DATA_L of word 3 of 5
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        check("rmid_wr_cnt", 32'(wr_cnt), 32'(wr_base + 2));
        check("rmid_addr_before", 32'(w_addr), 32'(1));
        rst = 1'b0;
        #1;
        check("rmid_wen",   32'(w_en),   32'(0));
        check("rmid_waddr", 32'(w_addr), 32'(0));
        check("rmid_din",   32'(din),    32'(0));
        check_idle_outputs("rmid", 1'b0, 1'b0);
        send_byte(8'h66);
        @(negedge clk);
        rst = 1'b1;
        send_byte(8'h77);
        @(negedge clk); #1;
        check("rmid_no_write", 32'(wr_cnt), 32'(wr_base + 2));
        check("rmid_idle_hold", 32'(cpu_hold), 32'(0));
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h88);
        send_byte(8'h99);
        check("rmid_restart_wen",  32'(w_en),   32'(1));
        check("rmid_restart_addr", 32'(w_addr), 32'(0));
        check("rmid_restart_din",  32'(din),    32'h8899);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h21);
`endif
        check_idle_outputs("rmid_restart", 1'b1, 1'b0);

        // Length 0 means 2^addr_width words
        @(negedge clk); #1;
        wr_base = wr_cnt;
        sum = 8'h00;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int i = 0; i < 16; i++) begin
            hi  = 8'(8'h11 * i);
            lo  = 8'(8'hF0 - i);
            sum = sum + hi + lo;
            send_byte(hi);
            send_byte(lo);
            check($sformatf("len0_addr%0d", i), 32'(w_addr), 32'(i));
            check($sformatf("len0_din%0d", i),  32'(din),    32'({hi, lo}));
            if (i < 15) check($sformatf("len0_busy%0d", i), 32'(cpu_hold), 32'(1));
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(sum);
`endif
        check_idle_outputs("len0", 1'b1, 1'b0);
        @(negedge clk); #1;
        check("len0_wr_cnt", 32'(wr_cnt), 32'(wr_base + 16));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
